lsu_ctrl: RTL
=============

# lsu_ctrl

Multi-cycle load/store unit sitting between the ALU's effective-address output and data memory. Accepts one RV32I load or store per handshake, converts it into a word-aligned memory request with byte strobes, waits for memory acknowledge, and returns sign- or zero-extended load data to the writeback path. It replaces the single-cycle combinational memory path and lets memory take any number of cycles.

## Interface
- WIDTH, 32, data/address width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents an access.
- req_ready  out  1  unit can accept; high only in IDLE.
- is_store  in  1  1 = store (sb/sh/sw), 0 = load.
- func3  in  3  RV32I width/sign code.
- addr  in  WIDTH  byte effective address from ALU.
- wdata  in  WIDTH  store data (rs2).
- resp_valid  out  1  one-cycle pulse: access finished.
- resp_err  out  1  valid with resp_valid; illegal func3 or misaligned.
- rdata  out  WIDTH  formatted load data, valid with resp_valid; 0 for stores/errors.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  write enable.
- mem_addr  out  WIDTH  word address ({addr[31:2],2'b00}).
- mem_wstrb  out  4  byte strobes; 0000 on loads.
- mem_wdata  out  WIDTH  lane-replicated store data.
- mem_ack  in  1  memory completion, one cycle.
- mem_rdata  in  WIDTH  read word, valid with mem_ack.

## Operation
- States: IDLE, ACCESS, RESP. Reset -> IDLE.
- IDLE: req_ready=1. On req_valid, latch is_store, func3, addr, wdata. Illegal/misaligned -> RESP with err=1 (no memory access); else -> ACCESS.
- ACCESS: mem_req=1, all mem_* held stable. On mem_ack: capture/format mem_rdata -> RESP. mem_ack outside ACCESS ignored.
- RESP: resp_valid=1 one cycle -> IDLE.
- Legal loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Legal stores: 000 sb, 001 sh, 010 sw. All others illegal.
- Load formatting: byte lane addr[1:0], half lane addr[1]; lb/lh sign-extend bit 7/15, lbu/lhu zero-extend.
- Store: sb strobe 0001<<addr[1:0], data {4{wdata[7:0]}}; sh strobe 0011<<(2*addr[1]), data {2{wdata[15:0]}}; sw 1111, wdata.
- Outputs when not in ACCESS: mem_req=0, mem_we=0, mem_wstrb=0, mem_addr/mem_wdata hold last value.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_err=0, rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0.
- Accept at edge T; mem_req high from T+1; mem_ack at T+1+k (k>=0, ack may arrive first ACCESS cycle); resp_valid at T+2+k; req_ready high again T+3+k. Minimum latency 2 cycles accept->resp.
- Error path: accept T, resp_valid/resp_err at T+1.
- req_ready low in ACCESS and RESP; req_valid there ignored. No back-to-back acceptance.
- rst asserted mid-access: mem_req drops immediately (asynchronous), pending access abandoned, no resp_valid.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: lh/lhu/sh with addr[0]=1 and lw/sw with addr[1:0]!=0 give resp_err=1, no memory request.
- Undefined: misalignment not checked; offending low address bits are forced to zero (natural alignment) and access proceeds normally with resp_err=0.

## Test plan
- sw addr=0x100 wdata=0xDEADBEEF, ack after 3 cycles -> mem_addr=0x100, wstrb=1111, mem_we=1, resp_valid 5 cycles after accept, rdata=0.
- sb addr=0x103 wdata=0x000000A5, ack immediately -> wstrb=1000, mem_wdata=0xA5A5A5A5, resp_valid at T+2.
- mem_rdata=0x80FF7F01 at 0x200: lb@0x203 -> 0xFFFFFF80; lbu@0x203 -> 0x00000080; lh@0x202 -> 0xFFFF80FF; lhu@0x200 -> 0x00007F01.
- func3=011 load -> resp_valid+resp_err at T+1, mem_req never asserted.
- lw addr=0x102: with LSU_MISALIGN_TRAP_EN -> resp_err=1, no mem_req; without -> mem_addr=0x100, normal response.
- rst pulsed while mem_req high -> mem_req=0 same cycle, req_ready=1, no resp_valid afterwards.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: multi-cycle RV32I load/store unit.
//
// Accepts one load or store per req_valid/req_ready handshake, issues a single
// word-aligned memory request with byte strobes, holds it until mem_ack and
// returns sign- or zero-extended load data as a one-cycle response pulse.
// Illegal func3 codes (and, optionally, misaligned accesses) are answered
// immediately with resp_err and never reach memory.
//
// Configuration macro:
//   LSU_MISALIGN_TRAP_EN  defined: misaligned lh/lhu/sh/lw/sw return resp_err.
//                         undefined: offending low address bits are ignored
//                         (natural alignment) and the access proceeds.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   req_valid/ready   request handshake; ready only while idle
//   is_store, func3   access type and RV32I width/sign code
//   addr, wdata       byte effective address and store data
//   resp_valid/err    one-cycle completion pulse and error flag
//   rdata             formatted load data (0 for stores and errors)
//   mem_req/we/addr/wstrb/wdata  memory request, held until mem_ack
//   mem_ack, mem_rdata           memory completion and read word

module lsu_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             is_store,
  input  logic [2:0]       func3,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [WIDTH-1:0] rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_wstrb,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } state_t;

  state_t state_q;

  // Request fields kept for formatting the load data when mem_ack arrives.
  logic       store_q;
  logic [2:0] func3_q;
  logic [1:0] off_q;

  // Decode of the incoming request.
  logic             req_illegal;
  logic             req_misalign;
  logic [1:0]       req_off;
  logic [3:0]       req_strb;
  logic [WIDTH-1:0] req_wdata;

  // Formatting of the returned read word.
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic [WIDTH-1:0] ld_data;

  always_comb begin
    req_illegal = 1'b0;
    if (is_store) begin
      case (func3)
        3'b000, 3'b001, 3'b010: req_illegal = 1'b0;
        default:                req_illegal = 1'b1;
      endcase
    end else begin
      case (func3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_illegal = 1'b0;
        default:                                 req_illegal = 1'b1;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // func3[1:0] encodes the access size for every legal load and store code.
  always_comb begin
    req_misalign = 1'b0;
    case (func3[1:0])
      2'b01:   req_misalign = addr[0];
      2'b10:   req_misalign = (addr[1:0] != 2'b00);
      default: req_misalign = 1'b0;
    endcase
  end
`else
  assign req_misalign = 1'b0;
`endif

  // Byte offset after natural alignment; halves use addr[1] only, words none.
  always_comb begin
    req_off = 2'b00;
    case (func3[1:0])
      2'b00:   req_off = addr[1:0];
      2'b01:   req_off = {addr[1], 1'b0};
      default: req_off = 2'b00;
    endcase
  end

  // Strobes and lane-replicated data: every lane carries the store value so
  // memory only has to honour the strobes.
  always_comb begin
    req_strb  = 4'b0000;
    req_wdata = wdata;
    case (func3[1:0])
      2'b00: begin
        req_strb  = 4'b0001 << req_off;
        req_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        req_strb  = 4'b0011 << req_off;
        req_wdata = {2{wdata[15:0]}};
      end
      default: begin
        req_strb  = 4'b1111;
        req_wdata = wdata;
      end
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (off_q)
      2'b00:   ld_byte = mem_rdata[7:0];
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    ld_data = '0;
    case (func3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = mem_rdata;
      3'b100:  ld_data = {24'h000000, ld_byte};
      3'b101:  ld_data = {16'h0000, ld_half};
      default: ld_data = '0;
    endcase
  end

  // All outputs are registered; asynchronous reset drops mem_req at once and
  // abandons any pending access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      store_q    <= 1'b0;
      func3_q    <= 3'b000;
      off_q      <= 2'b00;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rdata      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= '0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            store_q   <= is_store;
            func3_q   <= func3;
            off_q     <= req_off;
            if (req_illegal || req_misalign) begin
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              rdata      <= '0;
            end else begin
              state_q   <= StAccess;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[WIDTH-1:2], 2'b00};
              mem_wstrb <= is_store ? req_strb : 4'b0000;
              if (is_store) begin
                mem_wdata <= req_wdata;
              end
            end
          end
        end
        StAccess: begin
          if (mem_ack) begin
            state_q    <= StResp;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_wstrb  <= 4'b0000;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            rdata      <= store_q ? '0 : ld_data;
          end
        end
        StResp: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
          resp_err  <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          req_ready <= 1'b1;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_wstrb <= 4'b0000;
        end
      endcase
    end
  end

endmodule
